// File: rtl/crc32_pkg.sv
// Shared CRC-32 constants, FSM state type and single-bit fold, used by the encoder and the checker.
package crc32_pkg;

    localparam int          CRC32_W      = 32;
    localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } crc32_state_t;

    // One MSB-first, non-reflected shift of the CRC register by a single data bit.
    function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic din);
        return {crc[30:0], 1'b0} ^ ((crc[31] ^ din) ? CRC32_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/crc32_slice_step.sv
// Combinational fold of one SLICE_WIDTH-bit slice (MSB first) into a CRC-32 state.
module crc32_slice_step
    import crc32_pkg::*;
#(
    parameter int SLICE_WIDTH = 64
) (
    input  logic [CRC32_W-1:0]     crc_i,
    input  logic [SLICE_WIDTH-1:0] slice_i,
    output logic [CRC32_W-1:0]     crc_o
);

    logic [CRC32_W-1:0] acc;

    always_comb begin
        acc = crc_i;
        for (int i = SLICE_WIDTH - 1; i >= 0; i--) begin
            acc = crc32_bit(acc, slice_i[i]);
        end
        crc_o = acc;
    end

endmodule

// File: rtl/crc32_chk.sv
// CRC-32 checker: captures a payload beat, folds it slice by slice, and reports the recomputed CRC.
// Optional feature: define CRC32_CHK_ERR_CNT_EN to add the saturating err_cnt_o error counter.
module crc32_chk
    import crc32_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int CRC_WIDTH   = 32,
    parameter int SLICE_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [CRC_WIDTH-1:0]  checksum_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CRC_WIDTH-1:0]  checksum_o,
    output logic                  crc_err_o
`ifdef CRC32_CHK_ERR_CNT_EN
    ,
    output logic [15:0]           err_cnt_o
`endif
);

    localparam int NUM_SLICES = (SLICE_WIDTH > 0) ? DATA_WIDTH / SLICE_WIDTH : 1;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NUM_SLICES - 1);

    if (DATA_WIDTH == 0 || SLICE_WIDTH == 0 || (DATA_WIDTH % SLICE_WIDTH) != 0 || CRC_WIDTH != 32)
    begin : g_bad_params
        $error("crc32_chk: DATA_WIDTH must be a non-zero multiple of SLICE_WIDTH and CRC_WIDTH must be 32");
    end

    crc32_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [CRC_WIDTH-1:0]   chk_q;
    logic [CRC_WIDTH-1:0]   crc_q;
    logic [CRC_WIDTH-1:0]   crc_next;
    logic [CRC_WIDTH-1:0]   crc_final;
    logic [CRC_WIDTH-1:0]   checksum_q;
    logic                   err_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [SLICE_WIDTH-1:0] slice;

    // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ready_o = (state_q == IDLE) && !rst;
        valid_o = (state_q == DONE);
        unique case (state_q)
            IDLE:    if (valid_i) state_d = CALC;
            CALC:    if (cnt_q == LAST_SLICE) state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Slice 0 is the top of the payload; constant-index mux keeps the select lint-clean.
    always_comb begin
        slice = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (cnt_q == CNT_W'(i)) slice = data_q[DATA_WIDTH - 1 - i * SLICE_WIDTH -: SLICE_WIDTH];
        end
    end

    crc32_slice_step #(
        .SLICE_WIDTH(SLICE_WIDTH)
    ) u_step (
        .crc_i  (crc_q),
        .slice_i(slice),
        .crc_o  (crc_next)
    );

    assign crc_final = crc_next ^ CRC32_XOROUT;

    // NOTE: the wide payload register is reset only because data_o must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            chk_q      <= '0;
            crc_q      <= '0;
            cnt_q      <= '0;
            checksum_q <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        data_q <= data_i;
                        chk_q  <= checksum_i;
                        crc_q  <= CRC32_INIT;
                        cnt_q  <= '0;
                    end
                end
                CALC: begin
                    crc_q <= crc_next;
                    if (cnt_q == LAST_SLICE) begin
                        cnt_q      <= '0;
                        checksum_q <= crc_final;
                        err_q      <= (crc_final != chk_q);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_o     = data_q;
    assign checksum_o = checksum_q;
    assign crc_err_o  = err_q;

`ifdef CRC32_CHK_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (state_q == DONE && ready_i && err_q && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc32_chk.sv
// Directed/random bench for crc32_chk against a byte-table CRC-32 reference model.
module tb_crc32_chk;
    import crc32_pkg::*;

    localparam int DW  = 512;
    localparam int SW  = 64;
    localparam int CW  = 32;
    localparam int LAT = DW / SW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_i;
    logic [CW-1:0] checksum_i;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_o;
    logic [CW-1:0] checksum_o;
    logic          crc_err_o;
`ifdef CRC32_CHK_ERR_CNT_EN
    logic [15:0]   err_cnt_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] crc_table [256];

    always #5 clk = ~clk;

    crc32_chk #(
        .DATA_WIDTH (DW),
        .CRC_WIDTH  (CW),
        .SLICE_WIDTH(SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_i    (data_i),
        .checksum_i(checksum_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .checksum_o(checksum_o),
        .crc_err_o (crc_err_o)
`ifdef CRC32_CHK_ERR_CNT_EN
        ,
        .err_cnt_o (err_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Byte-at-a-time table CRC over the payload, most significant byte first.
    function automatic logic [31:0] ref_crc(input logic [DW-1:0] d);
        logic [31:0] c;
        logic [7:0]  b;
        c = CRC32_INIT;
        for (int k = DW / 8 - 1; k >= 0; k--) begin
            b = d[k*8 +: 8];
            c = {c[23:0], 8'h00} ^ crc_table[c[31:24] ^ b];
        end
        return c ^ CRC32_XOROUT;
    endfunction

    task automatic start_beat(input logic [DW-1:0] d, input logic [CW-1:0] c, input string tag);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ":ready_before"}, DW'(ready_o), DW'(1));
        data_i     = d;
        checksum_i = c;
        valid_i    = 1'b1;
        @(posedge clk);
        #1;
        valid_i    = 1'b0;
        data_i     = rand_data();
        checksum_i = $urandom();
    endtask

    // Latency counts the handshake edge as 1; valid_o must be seen after exactly LAT edges.
    task automatic wait_result(input logic [DW-1:0] d, input logic exp_err, input string tag);
        int lat;
        lat = 1;
        while (!valid_o && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ":latency"}, DW'(lat), DW'(LAT));
        check({tag, ":data_o"}, data_o, d);
        check({tag, ":checksum_o"}, DW'(checksum_o), DW'(ref_crc(d)));
        check({tag, ":crc_err_o"}, DW'(crc_err_o), DW'(exp_err));
    endtask

    task automatic end_beat(input string tag);
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        check({tag, ":valid_after_hs"}, DW'(valid_o), DW'(0));
        check({tag, ":ready_after_hs"}, DW'(ready_o), DW'(1));
    endtask

    task automatic do_beat(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic exp_err,
                           input string tag);
        start_beat(d, c, tag);
        wait_result(d, exp_err, tag);
        end_beat(tag);
    endtask

    initial begin
        logic [DW-1:0] d, d2;
        logic [CW-1:0] c;
        logic          seen;

        for (int i = 0; i < 256; i++) begin
            logic [31:0] t;
            t = 32'(i) << 24;
            for (int j = 0; j < 8; j++) t = t[31] ? ((t << 1) ^ CRC32_POLY) : (t << 1);
            crc_table[i] = t;
        end

        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = '0; checksum_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst:ready_o", DW'(ready_o), DW'(0));
        check("rst:valid_o", DW'(valid_o), DW'(0));
        check("rst:data_o", data_o, '0);
        check("rst:checksum_o", DW'(checksum_o), DW'(0));
        check("rst:crc_err_o", DW'(crc_err_o), DW'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst:ready_idle", DW'(ready_o), DW'(1));

        for (int i = 0; i < 4; i++) begin
            d = rand_data();
            do_beat(d, ref_crc(d), 1'b0, "good");
        end

        d = rand_data();
        do_beat(d ^ DW'(1), ref_crc(d), 1'b1, "flip_data0");
        do_beat(d, ref_crc(d) ^ 32'h8000_0000, 1'b1, "flip_chk31");

        // Result held while ready_i is low; a second beat waits until after the handshake.
        d  = rand_data();
        d2 = rand_data();
        start_beat(d, ref_crc(d), "hold");
        wait_result(d, 1'b0, "hold");
        @(negedge clk);
        valid_i = 1'b1; data_i = d2; checksum_i = ref_crc(d2);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold:valid_o", DW'(valid_o), DW'(1));
            check("hold:ready_o", DW'(ready_o), DW'(0));
            check("hold:data_o", data_o, d);
            check("hold:checksum_o", DW'(checksum_o), DW'(ref_crc(d)));
            check("hold:crc_err_o", DW'(crc_err_o), DW'(0));
        end
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        check("hold:valid_hs", DW'(valid_o), DW'(0));
        check("hold:ready_hs", DW'(ready_o), DW'(1));
        check("hold:no_same_cycle", data_o, d);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        data_i  = rand_data();
        check("hold2:ready_busy", DW'(ready_o), DW'(0));
        check("hold2:captured", data_o, d2);
        wait_result(d2, 1'b0, "hold2");
        end_beat("hold2");

        // Reset in the fourth CALC cycle aborts the beat with no result.
        d = rand_data();
        start_beat(d, ref_crc(d), "abort");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort:ready_in_rst", DW'(ready_o), DW'(0));
        check("abort:valid_o", DW'(valid_o), DW'(0));
        check("abort:data_o", data_o, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort:ready_o", DW'(ready_o), DW'(1));
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (valid_o) seen = 1'b1;
        end
        check("abort:no_result", DW'(seen), DW'(0));

        do_beat('0, ref_crc('0), 1'b0, "zero_good");
        do_beat('0, '0, 1'b1, "zero_badchk");

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`ifdef CRC32_CHK_ERR_CNT_EN
        check("cnt:after_rst", DW'(err_cnt_o), DW'(0));
`endif
        for (int i = 0; i < 10; i++) begin
            logic bad;
            bad = (i == 2) || (i == 5) || (i == 8);
            d = rand_data();
            c = ref_crc(d) ^ (bad ? (32'h1 << $urandom_range(31, 0)) : 32'h0);
            do_beat(d, c, bad, "burst");
        end
`ifdef CRC32_CHK_ERR_CNT_EN
        check("cnt:three", DW'(err_cnt_o), DW'(3));
        @(negedge clk);
        force dut.err_cnt_q = 16'hFFFE;
        #1;
        release dut.err_cnt_q;
        for (int i = 0; i < 2; i++) begin
            d = rand_data();
            do_beat(d, ~ref_crc(d), 1'b1, "sat");
        end
        check("cnt:saturate", DW'(err_cnt_o), DW'(16'hFFFF));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
